// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the 8-bit teaching CPU control path.
//   opcode_t : 4-bit instruction opcodes (instr[15:12])
//   state_t  : fetch/execute sequencer states
//   *_DEFAULT: default instruction, program address and data widths
//   OPC_*/IMM_*: bit positions of the opcode and immediate fields
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int IW_DEFAULT = 16;
    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_ANDI = 4'h4,
        OP_ORI  = 4'h5,
        OP_XORI = 4'h6,
        OP_IN   = 4'h7,
        OP_OUT  = 4'h8,
        OP_JMP  = 4'h9,
        OP_JMPC = 4'hA,
        OP_JMPZ = 4'hB,
        OP_CALL = 4'hC,
        OP_RET  = 4'hD,
        OP_HALT = 4'hE,
        OP_RSVD = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// ----------------------------------------------------------------------------
// cpu_alu
// Combinational accumulator datapath. Given the decoded opcode and the current
// accumulator/carry, produces the values to be registered at the end of EXEC.
// Ports:
//   opcode     in   decoded instruction opcode
//   acc        in   current accumulator
//   imm        in   immediate operand (instr[7:0])
//   data_in    in   external input port, used by IN
//   carry      in   current carry/borrow flag
//   acc_next   out  new accumulator value (meaningful when acc_we=1)
//   carry_next out  new carry flag (equals carry for ops that leave it alone)
//   acc_we     out  accumulator write enable
// ----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  opcode_t         opcode,
    input  logic [DW-1:0]   acc,
    input  logic [DW-1:0]   imm,
    input  logic [DW-1:0]   data_in,
    input  logic            carry,
    output logic [DW-1:0]   acc_next,
    output logic            carry_next,
    output logic            acc_we
);

    logic [DW:0] sum;

    // ADDI needs the ninth bit of the sum as its carry out.
    assign sum = {1'b0, acc} + {1'b0, imm};

    always_comb begin
        acc_next   = acc;
        carry_next = carry;
        acc_we     = 1'b0;
        case (opcode)
            OP_LDI: begin
                acc_next = imm;
                acc_we   = 1'b1;
            end
            OP_ADDI: begin
                acc_next   = sum[DW-1:0];
                carry_next = sum[DW];
                acc_we     = 1'b1;
            end
            // Borrow is set when the subtrahend exceeds the accumulator.
            OP_SUBI: begin
                acc_next   = acc - imm;
                carry_next = (imm > acc);
                acc_we     = 1'b1;
            end
            OP_ANDI: begin
                acc_next = acc & imm;
                acc_we   = 1'b1;
            end
            OP_ORI: begin
                acc_next = acc | imm;
                acc_we   = 1'b1;
            end
            OP_XORI: begin
                acc_next = acc ^ imm;
                acc_we   = 1'b1;
            end
            OP_IN: begin
                acc_next = data_in;
                acc_we   = 1'b1;
            end
            default: begin
                acc_next   = acc;
                carry_next = carry;
                acc_we     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer
// Two-cycle fetch/execute control unit for the 8-bit teaching CPU. Decodes the
// instruction word from block memory, updates the accumulator and carry,
// issues one PC command pulse per instruction and drives the I/O ports.
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   run            in   run enable, sampled in FETCH
//   instr_in       in   instruction word, valid during EXEC
//   data_in        in   external input port (IN)
//   pc_inc         out  PC increment pulse
//   pc_jmp         out  PC jump pulse
//   pc_call        out  PC call pulse
//   pc_ret         out  PC return pulse
//   pc_addr        out  jump/call target, instr_in[7:0]
//   acc_out        out  accumulator (registered)
//   carry          out  carry/borrow flag (registered)
//   data_out       out  output port (registered, updated by OUT)
//   data_out_valid out  one-cycle strobe after data_out updates
//   halted         out  high while in HALT
// ----------------------------------------------------------------------------
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int IW = IW_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [IW-1:0]   instr_in,
    input  logic [DW-1:0]   data_in,
    output logic            pc_inc,
    output logic            pc_jmp,
    output logic            pc_call,
    output logic            pc_ret,
    output logic [AW-1:0]   pc_addr,
    output logic [DW-1:0]   acc_out,
    output logic            carry,
    output logic [DW-1:0]   data_out,
    output logic            data_out_valid,
    output logic            halted
);

    state_t        state;
    opcode_t       opcode;
    logic [DW-1:0] imm;
    logic [DW-1:0] acc_next;
    logic          carry_next;
    logic          acc_we;
    logic [3:0]    unused_bits;

    assign opcode      = opcode_t'(instr_in[OPC_HI:OPC_LO]);
    assign imm         = DW'(instr_in[IMM_HI:IMM_LO]);
    assign pc_addr     = AW'(instr_in[IMM_HI:IMM_LO]);
    assign unused_bits = instr_in[11:8];

    cpu_alu #(
        .DW(DW)
    ) u_alu (
        .opcode    (opcode),
        .acc       (acc_out),
        .imm       (imm),
        .data_in   (data_in),
        .carry     (carry),
        .acc_next  (acc_next),
        .carry_next(carry_next),
        .acc_we    (acc_we)
    );

    // PC command decode. Only EXEC issues a pulse, and the conditional jumps
    // look at the acc/carry still held from before this instruction.
    always_comb begin
        pc_inc  = 1'b0;
        pc_jmp  = 1'b0;
        pc_call = 1'b0;
        pc_ret  = 1'b0;
        if (state == EXEC) begin
            case (opcode)
                OP_JMP:  pc_jmp = 1'b1;
                OP_JMPC: begin
                    if (carry) pc_jmp = 1'b1;
                    else       pc_inc = 1'b1;
                end
                OP_JMPZ: begin
                    if (acc_out == '0) pc_jmp = 1'b1;
                    else               pc_inc = 1'b1;
                end
                OP_CALL: pc_call = 1'b1;
                OP_RET:  pc_ret  = 1'b1;
                OP_HALT: pc_inc  = 1'b0;
                default: pc_inc  = 1'b1;
            endcase
        end
    end

    // Sequencer state plus all registered outputs. Everything an instruction
    // changes is committed on the edge that ends EXEC; HALT only leaves on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FETCH;
            acc_out        <= '0;
            carry          <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            halted         <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (run) state <= EXEC;
                end
                EXEC: begin
                    if (acc_we) acc_out <= acc_next;
                    carry <= carry_next;
                    if (opcode == OP_OUT) begin
                        data_out       <= acc_out;
                        data_out_valid <= 1'b1;
                    end
                    if (opcode == OP_HALT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ctrl_sequencer
// Directed testbench for ctrl_sequencer. Instructions are driven one at a time
// with hand-computed pulse, accumulator, carry and I/O expectations.
// ----------------------------------------------------------------------------
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] instr_in;
    logic [7:0]  data_in;
    logic        pc_inc;
    logic        pc_jmp;
    logic        pc_call;
    logic        pc_ret;
    logic [7:0]  pc_addr;
    logic [7:0]  acc_out;
    logic        carry;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        halted;

    int testCount;
    int failCount;

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_INC  = 4'b1000;
    localparam logic [3:0] P_JMP  = 4'b0100;
    localparam logic [3:0] P_CALL = 4'b0010;
    localparam logic [3:0] P_RET  = 4'b0001;

    ctrl_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .instr_in      (instr_in),
        .data_in       (data_in),
        .pc_inc        (pc_inc),
        .pc_jmp        (pc_jmp),
        .pc_call       (pc_call),
        .pc_ret        (pc_ret),
        .pc_addr       (pc_addr),
        .acc_out       (acc_out),
        .carry         (carry),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .halted        (halted)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck run still terminates with a failure reported.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one instruction from FETCH through EXEC with run held high. On entry
    // the sequencer is in FETCH just after a clock edge; on exit it is just past
    // the edge that ends EXEC, so registered results are visible to the caller.
    task automatic applyStimulus(input string tag, input logic [15:0] instr,
                                 input logic [3:0] expPulse, input logic [7:0] expAddr);
        instr_in = instr;
        run      = 1'b1;
        checkOutput({tag, " fetch pulses"}, {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, {28'd0, P_NONE});
        @(posedge clk);
        #1;
        checkOutput({tag, " exec pulses"}, {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, {28'd0, expPulse});
        if (expPulse == P_JMP || expPulse == P_CALL)
            checkOutput({tag, " pc_addr"}, {24'd0, pc_addr}, {24'd0, expAddr});
        @(posedge clk);
        #1;
    endtask

    // Checks accumulator and carry together after an instruction commits.
    task automatic checkAcc(input string tag, input logic [7:0] expAcc, input logic expCarry);
        checkOutput({tag, " acc"}, {24'd0, acc_out}, {24'd0, expAcc});
        checkOutput({tag, " carry"}, {31'd0, carry}, {31'd0, expCarry});
    endtask

    // Main directed sequence.
    initial begin
        testCount = 0;
        failCount = 0;
        rst       = 1'b1;
        run       = 1'b0;
        instr_in  = 16'h0000;
        data_in   = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        checkAcc("reset", 8'h00, 1'b0);
        checkOutput("reset data_out", {24'd0, data_out}, 32'd0);
        checkOutput("reset valid", {31'd0, data_out_valid}, 32'd0);
        checkOutput("reset halted", {31'd0, halted}, 32'd0);
        checkOutput("reset pulses", {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, 32'd0);
        rst = 1'b0;

        // run low keeps the block in FETCH even with an instruction present.
        instr_in = 16'h1077;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle pulses", {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, 32'd0);
            checkOutput("idle acc", {24'd0, acc_out}, 32'd0);
        end

        // Load and add with carry out of the top bit.
        applyStimulus("ldi05", 16'h1005, P_INC, 8'h00);
        checkAcc("ldi05", 8'h05, 1'b0);
        applyStimulus("addiFC", 16'h20FC, P_INC, 8'h00);
        checkAcc("addiFC", 8'h01, 1'b1);

        // Subtraction with and without borrow.
        applyStimulus("ldi03", 16'h1003, P_INC, 8'h00);
        checkAcc("ldi03", 8'h03, 1'b1);
        applyStimulus("subi05", 16'h3005, P_INC, 8'h00);
        checkAcc("subi05", 8'hFE, 1'b1);
        applyStimulus("subi0E", 16'h300E, P_INC, 8'h00);
        checkAcc("subi0E", 8'hF0, 1'b0);

        // Conditional jumps on carry and zero.
        applyStimulus("jmpc nc", 16'hA040, P_INC, 8'h40);
        applyStimulus("ldiFF", 16'h10FF, P_INC, 8'h00);
        applyStimulus("addi01", 16'h2001, P_INC, 8'h00);
        checkAcc("addi01", 8'h00, 1'b1);
        applyStimulus("jmpc c", 16'hA040, P_JMP, 8'h40);
        applyStimulus("jmpz z", 16'hB022, P_JMP, 8'h22);
        applyStimulus("jmp", 16'h9033, P_JMP, 8'h33);

        // Logic ops leave carry alone; JMPZ with a non-zero acc falls through.
        applyStimulus("ldiF0", 16'h10F0, P_INC, 8'h00);
        applyStimulus("jmpz nz", 16'hB022, P_INC, 8'h22);
        applyStimulus("andi3C", 16'h403C, P_INC, 8'h00);
        checkAcc("andi3C", 8'h30, 1'b1);
        applyStimulus("ori05", 16'h5005, P_INC, 8'h00);
        checkAcc("ori05", 8'h35, 1'b1);
        applyStimulus("xoriFF", 16'h60FF, P_INC, 8'h00);
        checkAcc("xoriFF", 8'hCA, 1'b1);

        // Input port read.
        data_in = 8'h5A;
        applyStimulus("in", 16'h7000, P_INC, 8'h00);
        checkAcc("in", 8'h5A, 1'b1);

        // Output port: one-cycle strobe, value held afterwards.
        applyStimulus("ldiA5", 16'h10A5, P_INC, 8'h00);
        applyStimulus("out", 16'h8000, P_INC, 8'h00);
        checkOutput("out data", {24'd0, data_out}, 32'h0000_00A5);
        checkOutput("out valid", {31'd0, data_out_valid}, 32'd1);
        applyStimulus("nop", 16'h0000, P_INC, 8'h00);
        checkOutput("hold data", {24'd0, data_out}, 32'h0000_00A5);
        checkOutput("hold valid", {31'd0, data_out_valid}, 32'd0);

        // Subroutine pulses and the reserved opcode.
        applyStimulus("call", 16'hC010, P_CALL, 8'h10);
        applyStimulus("ret", 16'hD000, P_RET, 8'h00);
        applyStimulus("rsvd", 16'hF012, P_INC, 8'h12);
        checkAcc("rsvd", 8'hA5, 1'b1);

        // Dropping run during EXEC still completes the instruction, then holds.
        instr_in = 16'h1033;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        checkOutput("rundrop exec", {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, {28'd0, P_INC});
        @(posedge clk);
        #1;
        checkOutput("rundrop acc", {24'd0, acc_out}, 32'h0000_0033);
        @(posedge clk);
        #1;
        checkOutput("rundrop held", {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, 32'd0);

        // Asynchronous reset in the middle of EXEC.
        instr_in = 16'h1099;
        run      = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("preRst exec", {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, {28'd0, P_INC});
        #2;
        rst = 1'b1;
        #1;
        checkOutput("execRst pulses", {28'd0, pc_inc, pc_jmp, pc_call, pc_ret}, 32'd0);
        checkAcc("execRst", 8'h00, 1'b0);
        checkOutput("execRst data_out", {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // HALT absorbs every instruction until reset.
        applyStimulus("ldi42", 16'h1042, P_INC, 8'h00);
        applyStimulus("out42", 16'h8000, P_INC, 8'h00);
        applyStimulus("halt", 16'hE000, P_NONE, 8'h00);
        checkOutput("halt halted", {31'd0, halted}, 32'd1);
        checkOutput("halt acc", {24'd0, acc_out}, 32'h0000_0042);
        for (int i = 0; i < 20; i++) begin
            instr_in = {i[3:0], 4'h0, 8'h10};
            @(posedge clk);
            #1;
            checkOutput("halt hold", {27'd0, halted, pc_inc, pc_jmp, pc_call, pc_ret}, 32'h0000_0010);
        end

        // Asynchronous reset out of HALT.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("haltRst halted", {31'd0, halted}, 32'd0);
        checkOutput("haltRst acc", {24'd0, acc_out}, 32'd0);
        checkOutput("haltRst data_out", {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal execution resumes after leaving HALT via reset.
        applyStimulus("postRst ldi", 16'h1007, P_INC, 8'h00);
        checkAcc("postRst ldi", 8'h07, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Fetch/execute control unit for the 8-bit teaching CPU. It sits directly downstream of the instruction block memory and upstream of the program counter. Each instruction is 16 bits and runs in two cycles (FETCH, EXEC). The block decodes the word, updates an 8-bit accumulator and a carry flag, drives the PC command pulses (inc/jmp/call/ret plus target address), and handles the I/O ports.

Parameters:
IW, 16, instruction width; opcode in [15:12], bits [11:8] unused, immediate/target in [7:0]
AW, 8, program address width, equal to PC width
DW, 8, accumulator and I/O data width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
run  input  1  run enable; sampled in FETCH
instr_in  input  IW  instruction word from block memory; valid during EXEC for the address the PC held during FETCH
data_in  input  DW  external input port, read by IN
pc_inc  output  1  PC increment pulse
pc_jmp  output  1  PC jump pulse
pc_call  output  1  PC call pulse
pc_ret  output  1  PC return pulse
pc_addr  output  AW  jump/call target = instr_in[7:0], unmodified; the PC applies its own offset
acc_out  output  DW  accumulator value (registered)
carry  output  1  carry/borrow flag (registered)
data_out  output  DW  output port, registered, holds its value between OUTs
data_out_valid  output  1  one-cycle strobe when data_out updates
halted  output  1  high while in HALT

Behaviour:
- Reset (asynchronous): state=FETCH, acc=0, carry=0, data_out=0, data_out_valid=0, halted=0. All pulses are 0.
- States: FETCH, EXEC, HALT.
  - FETCH: no pulses. If run=1, go to EXEC next cycle; otherwise stay in FETCH.
  - EXEC: decode instr_in and issue at most one PC pulse. Next state is FETCH, or HALT on the HALT opcode.
  - HALT: absorbing. No pulses, halted=1. Only rst exits.
- PC pulses are combinational from (state==EXEC, instr_in, carry, acc). They are mutually exclusive and are 0 outside EXEC. pc_addr = instr_in[7:0] always; it is don't-care when no jmp/call is asserted.
- Registered updates (acc, carry, data_out, data_out_valid, state) take effect at the posedge that ends EXEC.
- Opcodes (imm = instr_in[7:0]):
  - 0 NOP: pc_inc.
  - 1 LDI: acc=imm; pc_inc.
  - 2 ADDI: {carry,acc} = acc + imm, 9-bit result; pc_inc.
  - 3 SUBI: acc = acc - imm, mod 256; carry = (imm > acc) (borrow); pc_inc.
  - 4 ANDI, 5 ORI, 6 XORI: acc = acc op imm; carry unchanged; pc_inc.
  - 7 IN: acc = data_in; pc_inc.
  - 8 OUT: data_out = acc; data_out_valid=1 for exactly one cycle (the FETCH cycle that follows); pc_inc.
  - 9 JMP: pc_jmp.
  - A JMPC: pc_jmp if carry=1, else pc_inc.
  - B JMPZ: pc_jmp if acc==0, else pc_inc.
  - C CALL: pc_call.
  - D RET: pc_ret.
  - E HALT: no pulse; go to HALT; acc/carry unchanged.
  - F reserved: executes as NOP.
- JMPC/JMPZ test the acc/carry values held at the start of EXEC.
- Return depth is one level, provided by the PC. A nested CALL overwrites the return address; the sequencer does not track depth.
- run=0 never truncates an EXEC in progress. It only holds the block in FETCH.
- rst asserted in any state, including EXEC or HALT, gives the reset values immediately, and pulses drop the same cycle.
- Throughput: one instruction per 2 cycles when run=1.

Decomposition:
- Package cpu_pkg:
  - opcode_t enum (4-bit, values above)
  - state_t enum {FETCH, EXEC, HALT}
  - localparams IW/AW/DW defaults
  - field slices OPC_HI=15, OPC_LO=12, IMM_HI=7, IMM_LO=0
- One natural sub-module: cpu_alu. It is combinational; inputs opcode, acc, imm, data_in, carry; outputs next acc, next carry, acc_we. The FSM, pulse decode and I/O registers stay in ctrl_sequencer.

Test Plan:
- Reset, then run=1, memory {0:LDI 0x05, 1:ADDI 0xFC} -> acc=0x05 after cycle 2; after cycle 4 acc=0x01, carry=1; pc_inc high exactly in cycles 2 and 4.
- acc=0x03, SUBI 0x05 -> acc=0xFE, carry=1; then SUBI 0x0E -> acc=0xF0, carry=0.
- JMPC 0x40 with carry=0 -> pc_inc only; with carry=1 -> pc_jmp=1, pc_addr=0x40, pc_inc=0. JMPZ 0x22 with acc=0x00 -> pc_jmp, pc_addr=0x22.
- LDI 0xA5; OUT -> data_out=0xA5, data_out_valid high for one cycle, then low while data_out holds 0xA5. CALL 0x10 / RET -> single pc_call, then single pc_ret.
- run=0 held for 5 cycles after reset -> state stays FETCH, no pulses, acc unchanged. Drop run mid-EXEC -> the instruction still completes.
- HALT -> halted=1, no pulses for 20 cycles regardless of instr_in. Assert rst mid-HALT and mid-EXEC -> all outputs return to reset values asynchronously.
